// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: prescaled down-counter with run/pause/abort control
// and optional auto-reload. All state is registered with a synchronous active-high clear.
module interval_timer_ctrl #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned PRE_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_sclr,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [BUS_WIDTH-1:0] i_load_val,
    input  logic [PRE_WIDTH-1:0] i_prescale,
    input  logic                 i_auto_reload,
    output logic [BUS_WIDTH-1:0] o_cnt,
    output logic [1:0]           o_state,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] load_q, load_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                 auto_q, auto_d;
    logic                 done_q, done_d;
    logic                 tick;

    // Next-state: start/stop handling, prescale tick and count update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;
        auto_d    = auto_q;
        done_d    = 1'b0;
        tick      = (pre_cnt_q == pre_q);

        unique case (state_q)
            StIdle, StDone: begin
                if (i_stop) begin
                    // Stop is a no-op in IDLE; from DONE it aborts back to IDLE
                    state_d = StIdle;
                end else if (i_start) begin
                    load_d    = i_load_val;
                    pre_d     = i_prescale;
                    auto_d    = i_auto_reload;
                    cnt_d     = i_load_val;
                    pre_cnt_d = '0;
                    if (i_load_val == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (i_stop) begin
                    // Freeze everything; a tick due this cycle is dropped
                    state_d = StPause;
                end else begin
                    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
                    if (tick) begin
                        if (cnt_q > BUS_WIDTH'(1)) begin
                            cnt_d = cnt_q - 1'b1;
                        end else if (auto_q) begin
                            cnt_d  = load_q;
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            StPause: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (i_start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous clear
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            load_q    <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
            auto_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
            auto_q    <= auto_d;
            done_q    <= done_d;
        end
    end

    // Outputs are straight from registers
    always_comb begin
        o_cnt   = cnt_q;
        o_state = state_q;
        o_busy  = (state_q == StRun) || (state_q == StPause);
        o_done  = done_q;
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench: directed scenarios plus randomized stimulus compared each cycle
// against a behavioural model of the timer.
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       sclr, start, stop, auto_rl;
    logic [7:0] load_val;
    logic [3:0] prescale;
    logic [7:0] cnt;
    logic [1:0] state;
    logic       busy, done;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: state code, count, cycles elapsed since the last tick
    int m_state, m_cnt, m_done, m_elapsed, m_load, m_pre, m_auto;

    interval_timer_ctrl #(
        .BUS_WIDTH(8),
        .PRE_WIDTH(4)
    ) dut (
        .i_clk        (clk),
        .i_sclr       (sclr),
        .i_start      (start),
        .i_stop       (stop),
        .i_load_val   (load_val),
        .i_prescale   (prescale),
        .i_auto_reload(auto_rl),
        .o_cnt        (cnt),
        .o_state      (state),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int nd;
        nd = 0;
        if (sclr) begin
            m_state = 0; m_cnt = 0; m_elapsed = 0;
            m_load = 0; m_pre = 0; m_auto = 0;
        end else begin
            case (m_state)
                0, 3: begin
                    if (stop) m_state = 0;
                    else if (start) begin
                        m_load = load_val; m_pre = prescale; m_auto = auto_rl;
                        m_cnt = load_val; m_elapsed = 0;
                        if (load_val == 0) begin m_state = 3; nd = 1; end
                        else m_state = 1;
                    end
                end
                1: begin
                    if (stop) m_state = 2;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == m_pre + 1) begin
                            m_elapsed = 0;
                            if (m_cnt > 1) m_cnt--;
                            else if (m_auto != 0) begin m_cnt = m_load; nd = 1; end
                            else begin m_cnt = 0; m_state = 3; nd = 1; end
                        end
                    end
                end
                default: begin
                    if (stop) m_state = 0;
                    else if (start) m_state = 1;
                end
            endcase
        end
        m_done = nd;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge
    task automatic cycle(input logic st, input logic sp, input logic sc,
                         input logic [7:0] ld, input logic [3:0] ps, input logic au);
        start = st; stop = sp; sclr = sc; load_val = ld; prescale = ps; auto_rl = au;
        @(posedge clk);
        model_step();
        #1;
        chk("o_cnt", int'(cnt), m_cnt);
        chk("o_state", int'(state), m_state);
        chk("o_busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
        chk("o_done", int'(done), m_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, load_val, prescale, auto_rl);
    endtask

    task automatic do_reset();
        cycle(0, 0, 1, 8'd0, 4'd0, 1'b0);
    endtask

    initial begin
        sclr = 1'b0; start = 1'b0; stop = 1'b0;
        load_val = '0; prescale = '0; auto_rl = 1'b0;
        m_state = 0; m_cnt = 0; m_done = 0; m_elapsed = 0;
        m_load = 0; m_pre = 0; m_auto = 0;
        @(negedge clk);

        // Reset state
        cycle(1, 1, 1, 8'd77, 4'd5, 1'b1);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);

        // Load 3, P=0, one-shot: 3,2,1,0 on consecutive cycles
        cycle(1, 0, 0, 8'd3, 4'd0, 1'b0);
        chk("os_cnt3", int'(cnt), 3);
        cycle(0, 0, 0, 8'd3, 4'd0, 1'b0);
        chk("os_cnt2", int'(cnt), 2);
        idle(1);
        chk("os_cnt1", int'(cnt), 1);
        chk("os_done_early", int'(done), 0);
        idle(1);
        chk("os_cnt0", int'(cnt), 0);
        chk("os_done", int'(done), 1);
        chk("os_state", int'(state), 3);
        idle(1);
        chk("os_done_once", int'(done), 0);
        chk("os_busy_after", int'(busy), 0);

        // Load 0 start: straight to DONE, then stop aborts to IDLE
        cycle(1, 0, 0, 8'd0, 4'd2, 1'b1);
        chk("z_state", int'(state), 3);
        chk("z_done", int'(done), 1);
        idle(1);
        chk("z_done_clr", int'(done), 0);
        cycle(0, 1, 0, 8'd0, 4'd2, 1'b1);
        chk("z_idle", int'(state), 0);

        // Auto-reload load 2, P=3: tick every 4 cycles, reload shows 2 with done
        do_reset();
        cycle(1, 0, 0, 8'd2, 4'd3, 1'b1);
        idle(3);
        chk("ar_hold", int'(cnt), 2);
        idle(1);
        chk("ar_cnt1", int'(cnt), 1);
        idle(3);
        chk("ar_done_early", int'(done), 0);
        idle(1);
        chk("ar_reload", int'(cnt), 2);
        chk("ar_done", int'(done), 1);
        chk("ar_state", int'(state), 1);

        // Pause/resume: load 5, P=1; 10 RUN cycles to expiry in total
        do_reset();
        cycle(1, 0, 0, 8'd5, 4'd1, 1'b0);
        idle(2);
        chk("pr_first_dec", int'(cnt), 4);
        cycle(0, 1, 0, 8'd5, 4'd1, 1'b0);
        chk("pr_pause", int'(state), 2);
        idle(3);
        chk("pr_frozen", int'(cnt), 4);
        cycle(1, 0, 0, 8'd9, 4'd7, 1'b1);
        chk("pr_resume", int'(state), 1);
        idle(7);
        chk("pr_cnt1", int'(cnt), 1);
        idle(1);
        chk("pr_expire", int'(cnt), 0);
        chk("pr_done", int'(done), 1);

        // start+stop together: no start from IDLE; RUN goes to PAUSE
        do_reset();
        cycle(1, 1, 0, 8'd4, 4'd0, 1'b0);
        chk("ss_idle", int'(state), 0);
        cycle(1, 0, 0, 8'd4, 4'd0, 1'b0);
        cycle(1, 1, 0, 8'd4, 4'd0, 1'b0);
        chk("ss_pause", int'(state), 2);
        chk("ss_cnt", int'(cnt), 4);
        chk("ss_nodone", int'(done), 0);

        // Clear mid-RUN with start high, then restart from 9
        do_reset();
        cycle(1, 0, 0, 8'd9, 4'd0, 1'b0);
        idle(3);
        chk("sc_cnt6", int'(cnt), 6);
        cycle(1, 0, 1, 8'd9, 4'd0, 1'b0);
        chk("sc_state", int'(state), 0);
        chk("sc_cnt", int'(cnt), 0);
        chk("sc_done", int'(done), 0);
        cycle(1, 0, 0, 8'd9, 4'd0, 1'b0);
        chk("sc_restart", int'(cnt), 9);

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            logic       r_st, r_sp, r_sc, r_au;
            logic [7:0] r_ld;
            logic [3:0] r_ps;
            r_sc = ($urandom_range(63) == 0);
            r_st = ($urandom_range(3) == 0);
            r_sp = ($urandom_range(9) == 0);
            r_ld = ($urandom_range(15) == 0) ? 8'($urandom) : 8'($urandom_range(5));
            r_ps = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(2));
            r_au = 1'($urandom);
            cycle(r_st, r_sp, r_sc, r_ld, r_ps, r_au);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
